// File: rtl/rand_pkg.sv
// rtl/rand_pkg.sv - shared types, default depth and seven-segment table for rand_history
package rand_pkg;

  typedef enum logic [0:0] {
    S_LIVE   = 1'b0,
    S_BROWSE = 1'b1
  } state_t;

  localparam int DEPTH_DEF = 4;

  // Active-low segments {g,f,e,d,c,b,a}; element 0 is the rightmost in the concatenation
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/seven_seg_dec.sv
// rtl/seven_seg_dec.sv - combinational hex digit to active-low seven-segment decoder
module seven_seg_dec
  import rand_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[digit];

endmodule

// File: rtl/rand_history.sv
// rtl/rand_history.sv - live random value display with browsable result history
// Optional registered seven-segment output enabled by RAND_HISTORY_SEG_EN.
module rand_history
  import rand_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  input  logic [3:0]               i_data,
  input  logic                     i_done,
  input  logic                     i_prev,
  output logic [3:0]               o_disp,
  output logic [$clog2(DEPTH)-1:0] o_idx,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_browse
`ifdef RAND_HISTORY_SEG_EN
  ,
  output logic [6:0]               o_seg
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       hist [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] idx_nxt;
  logic [PTR_W-1:0] rd_ptr;
  logic [3:0]       live;
  logic [3:0]       disp_nxt;
  logic             load_hist;
  logic             at_oldest;

  assign at_oldest = ({1'b0, o_idx} + CNT_W'(1)) >= o_count;
  // Entry shown at history index n sits n+1 slots behind the write pointer
  assign rd_ptr    = wr_ptr - PTR_W'(1) - idx_nxt;

  always_comb begin
    state_nxt = state;
    idx_nxt   = o_idx;
    disp_nxt  = o_disp;
    load_hist = 1'b0;
    if (i_done || i_valid) begin
      state_nxt = S_LIVE;
      idx_nxt   = '0;
      disp_nxt  = i_data;
    end else if (i_prev) begin
      if (state == S_LIVE) begin
        if (o_count != '0) begin
          state_nxt = S_BROWSE;
          idx_nxt   = '0;
          load_hist = 1'b1;
        end
      end else if (!at_oldest) begin
        idx_nxt   = o_idx + PTR_W'(1);
        load_hist = 1'b1;
      end else begin
        state_nxt = S_LIVE;
        idx_nxt   = '0;
        disp_nxt  = live;
      end
    end
    if (load_hist) begin
      disp_nxt = hist[rd_ptr];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= S_LIVE;
      o_disp   <= '0;
      o_idx    <= '0;
      o_count  <= '0;
      o_browse <= 1'b0;
      wr_ptr   <= '0;
      live     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        hist[i] <= '0;
      end
    end else begin
      state    <= state_nxt;
      o_disp   <= disp_nxt;
      o_idx    <= idx_nxt;
      o_browse <= (state_nxt == S_BROWSE);
      if (i_done || i_valid) begin
        live <= i_data;
      end
      if (i_done) begin
        hist[wr_ptr] <= i_data;
        wr_ptr       <= wr_ptr + PTR_W'(1);
        if (o_count != CNT_W'(DEPTH)) begin
          o_count <= o_count + CNT_W'(1);
        end
      end
    end
  end

`ifdef RAND_HISTORY_SEG_EN
  logic [6:0] seg_nxt;

  seven_seg_dec u_seg_dec (
    .digit (disp_nxt),
    .seg   (seg_nxt)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_seg <= 7'b1000000;
    end else begin
      o_seg <= seg_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_rand_history.sv
// tb/tb_rand_history.sv - self-checking bench for rand_history (DEPTH=4, RAND_HISTORY_SEG_EN optional)
module tb_rand_history;

  localparam int DEPTH = 4;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_valid;
  logic [3:0] i_data;
  logic       i_done;
  logic       i_prev;
  logic [3:0] o_disp;
  logic [1:0] o_idx;
  logic [2:0] o_count;
  logic       o_browse;
`ifdef RAND_HISTORY_SEG_EN
  logic [6:0] o_seg;
`endif

  rand_history #(.DEPTH(DEPTH)) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_valid  (i_valid),
    .i_data   (i_data),
    .i_done   (i_done),
    .i_prev   (i_prev),
    .o_disp   (o_disp),
    .o_idx    (o_idx),
    .o_count  (o_count),
    .o_browse (o_browse)
`ifdef RAND_HISTORY_SEG_EN
    ,
    .o_seg    (o_seg)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  // Reference: newest result at the front of the queue
  logic [3:0] m_hist[$];
  logic [3:0] m_live;
  logic [3:0] m_disp;
  int         m_idx;
  bit         m_browse;

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'h0: seg_of = 7'h40; 4'h1: seg_of = 7'h79; 4'h2: seg_of = 7'h24; 4'h3: seg_of = 7'h30;
      4'h4: seg_of = 7'h19; 4'h5: seg_of = 7'h12; 4'h6: seg_of = 7'h02; 4'h7: seg_of = 7'h78;
      4'h8: seg_of = 7'h00; 4'h9: seg_of = 7'h10; 4'hA: seg_of = 7'h08; 4'hB: seg_of = 7'h03;
      4'hC: seg_of = 7'h46; 4'hD: seg_of = 7'h21; 4'hE: seg_of = 7'h06; default: seg_of = 7'h0E;
    endcase
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".disp"},   {4'd0, o_disp},   {4'd0, m_disp});
    check({tag, ".idx"},    {6'd0, o_idx},    8'(m_idx));
    check({tag, ".count"},  {5'd0, o_count},  8'(m_hist.size()));
    check({tag, ".browse"}, {7'd0, o_browse}, {7'd0, m_browse});
`ifdef RAND_HISTORY_SEG_EN
    check({tag, ".seg"},    {1'b0, o_seg},    {1'b0, seg_of(m_disp)});
`endif
  endtask

  task automatic model_reset();
    m_hist.delete();
    m_live   = 4'd0;
    m_disp   = 4'd0;
    m_idx    = 0;
    m_browse = 1'b0;
  endtask

  task automatic model_step(input bit v, input bit d, input bit p, input logic [3:0] data);
    if (d) begin
      m_hist.push_front(data);
      if (m_hist.size() > DEPTH) void'(m_hist.pop_back());
      m_live = data; m_disp = data; m_browse = 0; m_idx = 0;
    end else if (v) begin
      m_live = data; m_disp = data; m_browse = 0; m_idx = 0;
    end else if (p) begin
      if (!m_browse) begin
        if (m_hist.size() > 0) begin
          m_browse = 1; m_idx = 0; m_disp = m_hist[0];
        end
      end else if (m_idx < m_hist.size() - 1) begin
        m_idx++; m_disp = m_hist[m_idx];
      end else begin
        m_browse = 0; m_idx = 0; m_disp = m_live;
      end
    end
  endtask

  // Drive one cycle of strobes at a falling edge, sample at the next falling edge
  task automatic cyc(input string tag, input bit v, input bit d, input bit p, input logic [3:0] data);
    @(negedge i_clk);
    i_valid = v; i_done = d; i_prev = p; i_data = data;
    @(negedge i_clk);
    i_valid = 0; i_done = 0; i_prev = 0;
    model_step(v, d, p, data);
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    @(negedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  initial begin
    i_rst_n = 1'b0; i_valid = 0; i_done = 0; i_prev = 0; i_data = 0;
    model_reset();
    repeat (2) @(negedge i_clk);
    check_all("reset");
    i_rst_n = 1'b1;

    cyc("prev_empty", 0, 0, 1, 4'h0);
    cyc("valid9", 1, 0, 0, 4'h9);
    cyc("valid4", 1, 0, 0, 4'h4);

    cyc("done3", 0, 1, 0, 4'h3);
    cyc("done7", 0, 1, 0, 4'h7);
    cyc("doneA", 0, 1, 0, 4'hA);
    for (int i = 0; i < 4; i++) cyc($sformatf("browse3_%0d", i), 0, 0, 1, 4'h0);

    async_reset("rst_a");
    for (int i = 1; i <= 5; i++) cyc($sformatf("fill_%0d", i), 0, 1, 0, 4'(i));
    for (int i = 0; i < 5; i++) cyc($sformatf("browse4_%0d", i), 0, 0, 1, 4'h0);

    cyc("b_idx0", 0, 0, 1, 4'h0);
    cyc("b_idx1", 0, 0, 1, 4'h0);
    cyc("valid6_exit", 1, 0, 1, 4'h6);
    cyc("b_again", 0, 0, 1, 4'h0);
    cyc("done8_prev", 1, 1, 1, 4'h8);
    cyc("b_show8", 0, 0, 1, 4'h0);
    cyc("b_next", 0, 0, 1, 4'h0);
    async_reset("rst_browse");
    cyc("doneF", 0, 1, 0, 4'hF);
    cyc("idle", 0, 0, 0, 4'h2);

    for (int n = 0; n < 400; n++) begin
      int r;
      bit v, d, p;
      r = int'($urandom_range(0, 99));
      d = (r < 15) || (r >= 95);
      v = (r >= 15 && r < 30) || (r >= 92);
      p = (r >= 30 && r < 80) || (r >= 90);
      cyc($sformatf("rnd%0d", n), v, d, p, 4'($urandom_range(0, 15)));
      if (n == 200) async_reset("rst_rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
